// File: rtl/dual_rail_counter_master.sv
// Clocked four-phase initiator for a self-timed 2-bit dual-rail counter; checks codewords and count order.
// Latency: SYNC_STAGES cycles per async input edge plus one cycle per FSM decision; value_valid one cycle after ack_s.
// Backpressure: waits on the counter's ack in each phase, bounded by TIMEOUT cycles, then parks in ERROR until clr_err.
module dual_rail_counter_master #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr_err,
    input  logic             ack,
    input  logic             a0,
    input  logic             a1,
    input  logic             b0,
    input  logic             b1,
    output logic             req,
    output logic [1:0]       value,
    output logic             value_valid,
    output logic             code_err,
    output logic             seq_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] txn_count,
    output logic             busy
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // Bit order inside each synchronizer stage: {ack, a1, a0, b1, b0}.
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic ack_s, a1_s, a0_s, b1_s, b0_s;
    logic pair_a_ok, pair_b_ok, spacer;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [1:0]         value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic               code_err_q, code_err_d;
    logic               seq_err_q, seq_err_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   txn_count_q, txn_count_d;
    logic [1:0]         exp_q, exp_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    // Multi-flop synchronizer chain for every counter output; only the last stage is observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {ack, a1, a0, b1, b0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign {ack_s, a1_s, a0_s, b1_s, b0_s} = sync_q[SYNC_STAGES-1];

    // A pair carries data only when exactly one rail is high; the spacer is all rails low.
    assign pair_a_ok = a0_s ^ a1_s;
    assign pair_b_ok = b0_s ^ b1_s;
    assign spacer    = ~(a0_s | a1_s | b0_s | b1_s);

    // State and datapath registers; reset drops req immediately without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            value_q       <= 2'd0;
            value_valid_q <= 1'b0;
            code_err_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            txn_count_q   <= '0;
            exp_q         <= 2'd0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            code_err_q    <= code_err_d;
            seq_err_q     <= seq_err_d;
            timeout_err_q <= timeout_err_d;
            txn_count_q   <= txn_count_d;
            exp_q         <= exp_d;
            timer_q       <= timer_d;
        end
    end

    // Handshake sequencing, codeword validation and sticky error bookkeeping.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        code_err_d    = code_err_q;
        seq_err_d     = seq_err_q;
        timeout_err_d = timeout_err_q;
        txn_count_d   = txn_count_q;
        exp_d         = exp_q;
        timer_d       = timer_q;

        // Clearing happens first so an error detected in the same cycle still sticks.
        if (clr_err) begin
            code_err_d    = 1'b0;
            seq_err_d     = 1'b0;
            timeout_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                req_d   = 1'b0;
                timer_d = '0;
                if (enable && !ack_s) begin
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                timer_d = timer_q + 1'b1;
                if (ack_s) begin
                    if (pair_a_ok && pair_b_ok) begin
                        value_d       = {a1_s, b1_s};
                        value_valid_d = 1'b1;
                        if ({a1_s, b1_s} != exp_q) begin
                            seq_err_d = 1'b1;
                        end
                        // Resynchronise on what the counter actually produced.
                        exp_d   = {a1_s, b1_s} + 2'd1;
                        req_d   = 1'b0;
                        timer_d = '0;
                        state_d = REQ_LO;
                    end else begin
                        code_err_d = 1'b1;
                        req_d      = 1'b0;
                        state_d    = ERROR;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    req_d         = 1'b0;
                    state_d       = ERROR;
                end
            end
            REQ_LO: begin
                req_d   = 1'b0;
                timer_d = timer_q + 1'b1;
                // Rails may lag ack on the return-to-zero phase; only the full spacer ends it.
                if (!ack_s && spacer) begin
                    txn_count_d = txn_count_q + 1'b1;
                    timer_d     = '0;
                    if (enable) begin
                        req_d   = 1'b1;
                        state_d = REQ_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ERROR;
                end
            end
            ERROR: begin
                req_d   = 1'b0;
                timer_d = '0;
                if (clr_err) begin
                    exp_d   = 2'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign req         = req_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign code_err    = code_err_q;
    assign seq_err     = seq_err_q;
    assign timeout_err = timeout_err_q;
    assign txn_count   = txn_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dual_rail_counter_master.sv
// Directed bench for dual_rail_counter_master with a behavioural dual-rail counter model.
// Latency: model answers on the falling edge after it sees req change.
// Backpressure: model can stall forever, hold a rail late, or emit an illegal codeword.
module tb_dual_rail_counter_master;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        clr_err = 1'b0;
    logic        ack     = 1'b0;
    logic        a0      = 1'b0;
    logic        a1      = 1'b0;
    logic        b0      = 1'b0;
    logic        b1      = 1'b0;
    logic        req;
    logic [1:0]  value;
    logic        value_valid;
    logic        code_err;
    logic        seq_err;
    logic        timeout_err;
    logic [15:0] txn_count;
    logic        busy;

    // Model controls (written only by the test tasks).
    bit          mdl_slow     = 1'b0;
    bit          mdl_silent   = 1'b0;
    bit          mdl_illegal  = 1'b0;
    bit          mdl_force_en = 1'b0;
    logic [1:0]  mdl_force_val = 2'd0;
    // Model state (written only by the model process).
    logic [1:0]  mdl_cnt  = 2'd0;
    logic [1:0]  mdl_v    = 2'd0;
    int          mdl_hold = 0;

    int errors = 0;
    int checks = 0;

    dual_rail_counter_master #(
        .SYNC_STAGES (2),
        .TIMEOUT     (10),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clr_err     (clr_err),
        .ack         (ack),
        .a0          (a0),
        .a1          (a1),
        .b0          (b0),
        .b1          (b1),
        .req         (req),
        .value       (value),
        .value_valid (value_valid),
        .code_err    (code_err),
        .seq_err     (seq_err),
        .timeout_err (timeout_err),
        .txn_count   (txn_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural four-phase dual-rail counter, acting on falling edges.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; a0 = 1'b0; a1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
                mdl_cnt = 2'd0; mdl_hold = 0;
            end else if (ack) begin
                if (!req) begin
                    ack = 1'b0; a0 = 1'b0; a1 = 1'b0;
                    if (mdl_slow) mdl_hold = 5;
                    else begin b0 = 1'b0; b1 = 1'b0; end
                end
            end else if (mdl_hold > 0) begin
                mdl_hold = mdl_hold - 1;
                if (mdl_hold == 0) begin b0 = 1'b0; b1 = 1'b0; end
            end else if (req && !mdl_silent) begin
                if (mdl_illegal) begin
                    a0 = 1'b1; a1 = 1'b1; b0 = 1'b1; b1 = 1'b0;
                end else begin
                    mdl_v = mdl_force_en ? mdl_force_val : mdl_cnt;
                    a1 = mdl_v[1]; a0 = ~mdl_v[1];
                    b1 = mdl_v[0]; b0 = ~mdl_v[0];
                    mdl_cnt = mdl_v + 2'd1;
                end
                ack = 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (req === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // One transaction: raise enable until req rises, then let it finish.
    task automatic run_one(output bit vv_seen, output logic [1:0] vv_val, output bit done);
        bit ok;
        vv_seen = 1'b0; vv_val = 2'd0; done = 1'b0;
        enable = 1'b1;
        wait_req(ok);
        enable = 1'b0;
        if (ok) begin
            for (int n = 0; n < 60; n++) begin
                tick();
                if (value_valid === 1'b1) begin vv_seen = 1'b1; vv_val = value; end
                if (busy === 1'b0) begin done = 1'b1; break; end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
        tick(); tick();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if (value !== 2'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", value); end
        checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_value_valid: got %b want 0", value_valid); end
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {code_err, seq_err, timeout_err}); end
        checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL reset_txn_count: got %0d want 0", txn_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (busy !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b req=%b want 0 0", busy, req); end
    endtask

    task automatic test_normal;
        bit got, ok;
        int extra;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            got = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                tick();
                if (value_valid === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || value !== 2'(i)) begin
                errors++; $display("FAIL normal_value[%0d]: got %0d (pulse=%b) want %0d", i, value, got, 2'(i));
            end
            if (i == 3) begin wait_req(ok); enable = 1'b0; end
        end
        extra = 0; ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (value_valid === 1'b1) extra++;
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL normal_stop: busy=%b want 0", busy); end
        checks++; if (extra != 0) begin errors++; $display("FAIL normal_extra_pulses: got %0d want 0", extra); end
        checks++; if (txn_count !== 16'd5) begin errors++; $display("FAIL normal_txn_count: got %0d want 5", txn_count); end
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL normal_flags: got %b want 000", {code_err, seq_err, timeout_err}); end
    endtask

    task automatic test_seq_fault;
        bit vs, dn;
        logic [1:0] vv;
        mdl_force_val = 2'd2; mdl_force_en = 1'b1;
        run_one(vs, vv, dn);
        mdl_force_en = 1'b0;
        checks++; if (!vs || vv !== 2'd2 || !dn) begin errors++; $display("FAIL seq_fault_value: got %0d (pulse=%b done=%b) want 2", vv, vs, dn); end
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_fault_flag: got %b want 1", seq_err); end
        run_one(vs, vv, dn);
        checks++; if (!vs || vv !== 2'd3 || !dn) begin errors++; $display("FAIL seq_resync_value: got %0d (pulse=%b done=%b) want 3", vv, vs, dn); end
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b010) begin errors++; $display("FAIL seq_sticky: got %b want 010", {code_err, seq_err, timeout_err}); end
        checks++; if (txn_count !== 16'd7) begin errors++; $display("FAIL seq_txn_count: got %0d want 7", txn_count); end
        pulse_clr();
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL clr_in_idle: flags=%b busy=%b want 000 0", {code_err, seq_err, timeout_err}, busy); end
    endtask

    task automatic test_illegal;
        bit ok, got;
        logic [15:0] base;
        logic [1:0]  val0;
        base = txn_count; val0 = value;
        mdl_illegal = 1'b1;
        enable = 1'b1;
        wait_req(ok);
        enable = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (code_err === 1'b1) begin got = 1'b1; break; end
        end
        checks++; if (!ok || !got) begin errors++; $display("FAIL illegal_code_err: got %b want 1", code_err); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL illegal_req: got %b want 0", req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL illegal_busy: got %b want 1", busy); end
        checks++; if (timeout_err !== 1'b0 || txn_count !== base || value !== val0) begin errors++; $display("FAIL illegal_side: tmo=%b cnt=%0d val=%0d want 0 %0d %0d", timeout_err, txn_count, value, base, val0); end
        repeat (8) tick();
        mdl_illegal = 1'b0;
        checks++; if (busy !== 1'b1 || code_err !== 1'b1) begin errors++; $display("FAIL illegal_stays_error: busy=%b code_err=%b want 1 1", busy, code_err); end
        pulse_clr();
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL illegal_clear: flags=%b busy=%b want 000 0", {code_err, seq_err, timeout_err}, busy); end
    endtask

    task automatic test_slow_release;
        bit vs, dn, ok, got, rel, early;
        logic [1:0]  vv;
        logic [15:0] base;
        base = txn_count;
        run_one(vs, vv, dn);
        checks++; if (!vs || vv !== 2'd0 || !dn) begin errors++; $display("FAIL slow_first_value: got %0d (pulse=%b done=%b) want 0", vv, vs, dn); end
        mdl_slow = 1'b1;
        enable = 1'b1;
        wait_req(ok);
        enable = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (value_valid === 1'b1) begin got = 1'b1; break; end
        end
        checks++; if (!ok || !got || value !== 2'd1) begin errors++; $display("FAIL slow_value: got %0d (pulse=%b) want 1", value, got); end
        rel = 1'b0; early = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (txn_count !== base + 16'd1) early = 1'b1;
            if (ack === 1'b0 && b1 === 1'b0) begin rel = 1'b1; break; end
        end
        checks++; if (!rel || early) begin errors++; $display("FAIL slow_early_count: count=%0d released=%b want %0d 1", txn_count, rel, base + 16'd1); end
        wait_idle(ok);
        checks++; if (!ok || txn_count !== base + 16'd2) begin errors++; $display("FAIL slow_count: got %0d want %0d", txn_count, base + 16'd2); end
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL slow_no_error: got %b want 000", {code_err, seq_err, timeout_err}); end
        mdl_slow = 1'b0;
    endtask

    task automatic test_timeout;
        bit ok;
        int first;
        logic [15:0] base;
        base = txn_count;
        mdl_silent = 1'b1;
        enable = 1'b1;
        wait_req(ok);
        enable = 1'b0;
        first = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (timeout_err === 1'b1) begin first = k; break; end
        end
        checks++; if (!ok || first != 10) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 10", first); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %b want 0", req); end
        checks++; if (busy !== 1'b1 || code_err !== 1'b0 || txn_count !== base) begin errors++; $display("FAIL timeout_side: busy=%b code_err=%b cnt=%0d want 1 0 %0d", busy, code_err, txn_count, base); end
        pulse_clr();
        mdl_silent = 1'b0;
        checks++; if ({code_err, seq_err, timeout_err} !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL timeout_clear: flags=%b busy=%b want 000 0", {code_err, seq_err, timeout_err}, busy); end
    endtask

    task automatic test_reset_mid;
        bit ok, vs, dn;
        logic [1:0] vv;
        enable = 1'b1;
        wait_req(ok);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (!ok || req !== 1'b0) begin errors++; $display("FAIL reset_mid_req: got %b want 0 (req seen=%b)", req, ok); end
        checks++; if (busy !== 1'b0 || txn_count !== 16'd0 || value !== 2'd0) begin errors++; $display("FAIL reset_mid_state: busy=%b cnt=%0d val=%0d want 0 0 0", busy, txn_count, value); end
        enable = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_one(vs, vv, dn);
        checks++; if (!vs || vv !== 2'd0 || !dn) begin errors++; $display("FAIL reset_mid_first: got %0d (pulse=%b done=%b) want 0", vv, vs, dn); end
        checks++; if (seq_err !== 1'b0 || txn_count !== 16'd1) begin errors++; $display("FAIL reset_mid_after: seq_err=%b cnt=%0d want 0 1", seq_err, txn_count); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_seq_fault();
        test_illegal();
        test_slow_release();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
